// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit add/sub sequencer: drives one external full-adder cell
// LSB first, one bit per clock, with a start/done handshake and result flags.
module serial_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-2:0] r_sumSh;
  logic [WIDTH-1:0] r_result;
  logic             r_carryOut;
  logic             r_overflow;
  logic             r_zero;

  logic             w_run;
  logic             w_accept;
  logic [WIDTH-1:0] w_sumNext;

  assign w_run     = (r_state == RUN);
  assign w_accept  = start && !abort && (r_state != RUN);
  assign w_sumNext = {fa_sum, r_sumSh};

  assign fa_a      = w_run & r_aSh[0];
  assign fa_b      = w_run & r_bSh[0];
  assign fa_cin    = w_run & r_carry;

  assign busy      = w_run;
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

  // Partial sum lives in r_sumSh so an aborted op never disturbs the
  // previously reported result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_sumSh    <= '0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_aSh   <= op_a;
            r_bSh   <= op_b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
            r_sumSh <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_sumSh <= w_sumNext[WIDTH-1:1];
            r_carry <= fa_cout;
            r_aSh   <= r_aSh >> 1;
            r_bSh   <= r_bSh >> 1;
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_result   <= w_sumNext;
              r_carryOut <= fa_cout;
              r_overflow <= r_carry ^ fa_cout;
              r_zero     <= (w_sumNext == '0);
              r_state    <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
